// File: rtl/display_mux_7seg.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display fed with BCD digits.
// Optional anti-ghosting blank at the start of each slot: define DISPLAY_MUX_GUARD_EN.
module display_mux_7seg #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Un,
  input  logic [3:0] De,
  input  logic [3:0] Ce,
  input  logic [3:0] Mi,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);

`ifdef DISPLAY_MUX_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       sel;

  logic [CNT_W-1:0] div_cnt_nxt_c;
  logic [1:0]       sel_nxt_c;
  logic             slot_end_c;
  logic             guard_c;
  logic [3:0]       digit_c;
  logic [3:0]       an_nxt_c;
  logic [6:0]       seg_nxt_c;

  // BCD to active-low segments {a,b,c,d,e,f,g}; 1010 blanks, 1011..1111 show a dash
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_OFF;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      4'd10:   s = 7'b1111111;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  // Refresh divider and scan counter next-state
  always_comb begin
    div_cnt_nxt_c = div_cnt + CNT_W'(1);
    sel_nxt_c     = sel;
    slot_end_c    = (div_cnt == CNT_LAST);
    if (slot_end_c) begin
      div_cnt_nxt_c = '0;
      sel_nxt_c     = sel + 2'd1;
    end
  end

  // Output selection for the current (pre-edge) slot
  always_comb begin
    digit_c   = Un;
    an_nxt_c  = AN_OFF;
    seg_nxt_c = SEG_OFF;
    guard_c   = GUARD_ON && (div_cnt < GUARD_LIM);
    case (sel)
      2'd0:    digit_c = Un;
      2'd1:    digit_c = De;
      2'd2:    digit_c = Ce;
      default: digit_c = Mi;
    endcase
    if (!guard_c) begin
      an_nxt_c      = AN_OFF;
      an_nxt_c[sel] = 1'b0;
      seg_nxt_c     = decode(digit_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sel     <= 2'd0;
      an      <= AN_OFF;
      seg     <= SEG_OFF;
    end else begin
      div_cnt <= div_cnt_nxt_c;
      sel     <= sel_nxt_c;
      an      <= an_nxt_c;
      seg     <= seg_nxt_c;
    end
  end

endmodule

// File: tb/tb_display_mux_7seg.sv
// Bench for display_mux_7seg: directed scan/reset/decode steps plus randomized digit changes,
// checked against a slot-arithmetic reference model.
module tb_display_mux_7seg;

  localparam int unsigned RD = 4;
  localparam int unsigned GC = 1;
`ifdef DISPLAY_MUX_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] dig [4];
  logic [3:0] un, de, ce, mi;
  logic [3:0] an;
  logic [6:0] seg;

  logic [6:0] dec [16];
  logic [3:0] cap [4];
  int         k;
  int         n_cmp;
  int         n_bad;

  assign un = dig[0];
  assign de = dig[1];
  assign ce = dig[2];
  assign mi = dig[3];

  display_mux_7seg #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .Un(un), .De(de), .Ce(ce), .Mi(mi), .an(an), .seg(seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge; model: edge k after reset release shows slot (k-1)/RD mod 4 at offset (k-1)%RD
  task automatic step(input string tag);
    int unsigned s, pos;
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = 0; i < 4; i++) cap[i] = dig[i];
    @(posedge clk);
    k++;
    #1;
    s   = ((k - 1) / RD) % 4;
    pos = (k - 1) % RD;
    if (GUARD && pos < GC) begin
      ea = 4'b1111;
      es = 7'b1111111;
    end else begin
      ea = 4'b1111 & ~(4'b0001 << s);
      es = dec[cap[s]];
    end
    chk({tag, "_an"}, {3'b000, an}, {3'b000, ea});
    chk({tag, "_seg"}, es, seg);
  endtask

  // Asynchronous reset pulse away from the edge, held across one edge, released mid-cycle
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_async_an"}, {3'b000, an}, 7'b0001111);
    chk({tag, "_async_seg"}, seg, 7'b1111111);
    @(posedge clk);
    #1;
    chk({tag, "_hold_an"}, {3'b000, an}, 7'b0001111);
    reset = 1'b0;
    k = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    k     = 0;
    dec[0]  = 7'b0000001; dec[1]  = 7'b1001111; dec[2]  = 7'b0010010; dec[3]  = 7'b0000110;
    dec[4]  = 7'b1001100; dec[5]  = 7'b0100100; dec[6]  = 7'b0100000; dec[7]  = 7'b0001111;
    dec[8]  = 7'b0000000; dec[9]  = 7'b0000100; dec[10] = 7'b1111111;
    for (int i = 11; i < 16; i++) dec[i] = 7'b1111110;

    dig[0] = 4'd0; dig[1] = 4'd3; dig[2] = 4'd10; dig[3] = 4'd10;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("por_an", {3'b000, an}, 7'b0001111);
    chk("por_seg", seg, 7'b1111111);
    reset = 1'b0;
    k = 0;

    // Run a while, then reset mid-run and scan one full frame plus wrap
    repeat (6) step("pre");
    do_reset("mid");
    step("first");
    if (!GUARD) chk("first_an_const", {3'b000, an}, 7'b0001110);
    repeat (16) step("scan");

    // Mid-slot change on the active units digit
    do_reset("r2");
    step("un0");
    dig[0] = 4'd5;
    step("un5");
    if (!GUARD) begin
      chk("midchg_seg", seg, 7'b0100100);
      chk("midchg_an", {3'b000, an}, 7'b0001110);
    end
    repeat (6) step("toce");

    // Invalid code in hundreds slot, then reset inside that slot
    dig[2] = 4'b1100;
    step("ce_bad");
    chk("ce_dash_seg", seg, 7'b1111110);
    chk("ce_dash_an", {3'b000, an}, 7'b0001011);
    do_reset("r3");
    repeat (8) step("post_r3");

    // Randomized digit changes at random moments
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) dig[$urandom_range(0, 3)] = 4'($urandom_range(0, 15));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
